// File: rtl/fetch_mem.sv
// Fetch-side imem stage: one outstanding req/ack fetch into an IF/ID buffer, latency 3+L cycles per instruction.
// Backpressure: while Decode stalls the buffer, the PC is held by feeding req_pc back to the PC-select register.
module fetch_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic [31:0] pc_4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [1:0]  id_fault,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [7:0] TO_LAST        = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_req_pc;
  logic [7:0]  r_cnt;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic [1:0]  r_id_fault;

  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_4;

  // The PC-select register has no enable, so every state must feed back the PC it wants next.
  always_comb begin
    w_pc_inc = r_req_pc + 32'd4;
    w_pc_4   = r_req_pc;
    case (r_state)
      S_IDLE:  w_pc_4 = pc_in;
      S_FULL:  w_pc_4 = (id_ready && !flush) ? w_pc_inc : r_req_pc;
      default: w_pc_4 = r_req_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_pc    <= 32'd0;
      r_cnt       <= 8'd0;
      r_imem_req  <= 1'b0;
      r_imem_addr <= 32'd0;
      r_id_valid  <= 1'b0;
      r_id_pc     <= 32'd0;
      r_id_instr  <= NOP_INSTR;
      r_id_fault  <= FAULT_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush) begin
            r_req_pc <= pc_in;
            if (pc_in[1:0] == 2'b00) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= pc_in;
              r_cnt       <= 8'd0;
              r_state     <= S_REQ;
            end else begin
              r_id_pc    <= pc_in;
              r_id_instr <= NOP_INSTR;
              r_id_fault <= FAULT_MISALIGN;
              r_id_valid <= 1'b1;
              r_state    <= S_FULL;
            end
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_id_pc    <= r_req_pc;
              r_id_instr <= imem_rdata;
              r_id_fault <= FAULT_NONE;
              r_id_valid <= 1'b1;
              r_state    <= S_FULL;
            end
          end else if (flush) begin
            // Request stays up: memory still owes us a response that must be absorbed.
            r_state <= S_DROP;
          end else if (r_cnt == TO_LAST) begin
            r_imem_req <= 1'b0;
            r_id_pc    <= r_req_pc;
            r_id_instr <= NOP_INSTR;
            r_id_fault <= FAULT_TIMEOUT;
            r_id_valid <= 1'b1;
            r_state    <= S_FULL;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_FULL: begin
          if (flush || id_ready) begin
            r_id_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc_4      = w_pc_4;
  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_fault  = r_id_fault;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fetch_mem.sv
// Directed bench for fetch_mem: each task drives a scenario and checks hand-computed values inline.
module tb_fetch_mem;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic [31:0] pc_4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [1:0]  id_fault;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_mem #(.TIMEOUT_CYCLES(4), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush), .pc_4(pc_4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_fault(id_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_in = 32'h10; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    tick(); tick();
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", id_valid); end
    n_chk++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", id_pc); end
    n_chk++; if (id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %0h want %0h", id_instr, NOP); end
    n_chk++; if (id_fault !== 2'b00) begin n_fail++; $display("FAIL reset_fault: got %0h want 0", id_fault); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_chk++; if (pc_4 !== 32'h10) begin n_fail++; $display("FAIL reset_pc4_idle: got %0h want 10", pc_4); end
    pc_in = 32'h0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    pc_in = 32'h0; id_ready = 1'b1;
    tick();
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %0h want 1", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %0h want 0", imem_addr); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0h want 1", busy); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    tick();
    imem_ack = 1'b0;
    #1;
    n_chk++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0h want 1", id_valid); end
    n_chk++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL basic_idpc: got %0h want 0", id_pc); end
    n_chk++; if (id_instr !== 32'h00500093) begin n_fail++; $display("FAIL basic_instr: got %0h want 00500093", id_instr); end
    n_chk++; if (id_fault !== 2'b00) begin n_fail++; $display("FAIL basic_fault: got %0h want 0", id_fault); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %0h want 0", imem_req); end
    n_chk++; if (pc_4 !== 32'h4) begin n_fail++; $display("FAIL basic_pc4: got %0h want 4", pc_4); end
    tick();
    pc_in = 32'h4;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clr: got %0h want 0", id_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0h want 0", busy); end
    tick();
    n_chk++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_addr: got %0h want 4", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h00100113;
    tick();
    imem_ack = 1'b0;
    n_chk++; if (id_instr !== 32'h00100113) begin n_fail++; $display("FAIL basic_instr2: got %0h want 00100113", id_instr); end
    n_chk++; if (id_pc !== 32'h4) begin n_fail++; $display("FAIL basic_idpc2: got %0h want 4", id_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    pc_in = 32'h20; id_ready = 1'b0;
    tick();
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL bp_addr: got %0h want 20", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h002081b3;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0h want 1", i, id_valid); end
      n_chk++; if (id_pc !== 32'h20) begin n_fail++; $display("FAIL bp_idpc[%0d]: got %0h want 20", i, id_pc); end
      n_chk++; if (id_instr !== 32'h002081b3) begin n_fail++; $display("FAIL bp_instr[%0d]: got %0h want 002081b3", i, id_instr); end
      n_chk++; if (pc_4 !== 32'h20) begin n_fail++; $display("FAIL bp_pc4[%0d]: got %0h want 20", i, pc_4); end
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req[%0d]: got %0h want 0", i, imem_req); end
      tick();
    end
    id_ready = 1'b1;
    #1;
    n_chk++; if (pc_4 !== 32'h24) begin n_fail++; $display("FAIL bp_pc4_release: got %0h want 24", pc_4); end
    tick();
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_clr: got %0h want 0", id_valid); end
  endtask

  task automatic test_flush_drop();
    pc_in = 32'h40; id_ready = 1'b1;
    tick();
    n_chk++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL drop_addr: got %0h want 40", imem_addr); end
    flush = 1'b1; pc_in = 32'h100;
    #1;
    n_chk++; if (pc_4 !== 32'h40) begin n_fail++; $display("FAIL drop_pc4_req: got %0h want 40", pc_4); end
    tick();
    flush = 1'b0;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_req_held1: got %0h want 1", imem_req); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %0h want 1", busy); end
    n_chk++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL drop_addr_held: got %0h want 40", imem_addr); end
    tick();
    flush = 1'b1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_req_held2: got %0h want 1", imem_req); end
    tick();
    flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hdeadbeef;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_req_held3: got %0h want 1", imem_req); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid: got %0h want 0", id_valid); end
    tick();
    imem_ack = 1'b0;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drop_req_done: got %0h want 0", imem_req); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %0h want 0", busy); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid_after: got %0h want 0", id_valid); end
    tick();
    n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL drop_redirect_addr: got %0h want 100", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h00000533;
    tick();
    imem_ack = 1'b0;
    n_chk++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL drop_redirect_idpc: got %0h want 100", id_pc); end
    n_chk++; if (id_instr !== 32'h00000533) begin n_fail++; $display("FAIL drop_redirect_instr: got %0h want 00000533", id_instr); end
    tick();
  endtask

  task automatic test_misaligned();
    pc_in = 32'h102; id_ready = 1'b0;
    tick();
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %0h want 0", imem_req); end
    n_chk++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %0h want 1", id_valid); end
    n_chk++; if (id_instr !== NOP) begin n_fail++; $display("FAIL mis_instr: got %0h want %0h", id_instr, NOP); end
    n_chk++; if (id_fault !== 2'b01) begin n_fail++; $display("FAIL mis_fault: got %0h want 1", id_fault); end
    n_chk++; if (id_pc !== 32'h102) begin n_fail++; $display("FAIL mis_idpc: got %0h want 102", id_pc); end
    n_chk++; if (pc_4 !== 32'h102) begin n_fail++; $display("FAIL mis_pc4_hold: got %0h want 102", pc_4); end
    id_ready = 1'b1; flush = 1'b1;
    #1;
    n_chk++; if (pc_4 !== 32'h102) begin n_fail++; $display("FAIL mis_flush_pc4: got %0h want 102", pc_4); end
    tick();
    flush = 1'b0;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush_valid: got %0h want 0", id_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_flush_idle: got %0h want 0", busy); end
  endtask

  task automatic test_timeout();
    pc_in = 32'h200; id_ready = 1'b0;
    tick();
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL to_req0: got %0h want 1", imem_req); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL to_req%0d: got %0h want 1", i, imem_req); end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid%0d: got %0h want 0", i, id_valid); end
    end
    tick();
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %0h want 0", imem_req); end
    n_chk++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL to_valid: got %0h want 1", id_valid); end
    n_chk++; if (id_fault !== 2'b10) begin n_fail++; $display("FAIL to_fault: got %0h want 2", id_fault); end
    n_chk++; if (id_instr !== NOP) begin n_fail++; $display("FAIL to_instr: got %0h want %0h", id_instr, NOP); end
    n_chk++; if (id_pc !== 32'h200) begin n_fail++; $display("FAIL to_idpc: got %0h want 200", id_pc); end
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    tick();
    imem_ack = 1'b0;
    n_chk++; if (id_instr !== NOP) begin n_fail++; $display("FAIL to_late_instr: got %0h want %0h", id_instr, NOP); end
    n_chk++; if (id_fault !== 2'b10) begin n_fail++; $display("FAIL to_late_fault: got %0h want 2", id_fault); end
    n_chk++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL to_late_valid: got %0h want 1", id_valid); end
    id_ready = 1'b1;
    #1;
    n_chk++; if (pc_4 !== 32'h204) begin n_fail++; $display("FAIL to_pc4: got %0h want 204", pc_4); end
    tick();
  endtask

  task automatic test_wrap();
    pc_in = 32'hFFFFFFFC; id_ready = 1'b1;
    tick();
    n_chk++; if (imem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_addr: got %0h want fffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000006f;
    tick();
    imem_ack = 1'b0;
    #1;
    n_chk++; if (id_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_idpc: got %0h want fffffffc", id_pc); end
    n_chk++; if (pc_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %0h want 0", pc_4); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    pc_in = 32'h300; id_ready = 1'b0;
    tick();
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %0h want 1", imem_req); end
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0h want 0", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
    n_chk++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_idpc: got %0h want 0", id_pc); end
    n_chk++; if (id_instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %0h want %0h", id_instr, NOP); end
    n_chk++; if (id_fault !== 2'b00) begin n_fail++; $display("FAIL rst_fault: got %0h want 0", id_fault); end
    imem_ack = 1'b1; imem_rdata = 32'hcafef00d;
    tick();
    imem_ack = 1'b0;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ack_ignored: got %0h want 0", id_valid); end
    pc_in = 32'h400; rst = 1'b1;
    tick();
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_resume_req: got %0h want 1", imem_req); end
    n_chk++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL rst_resume_addr: got %0h want 400", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h00a00593;
    tick();
    imem_ack = 1'b0;
    n_chk++; if (id_pc !== 32'h400) begin n_fail++; $display("FAIL rst_resume_idpc: got %0h want 400", id_pc); end
    n_chk++; if (id_instr !== 32'h00a00593) begin n_fail++; $display("FAIL rst_resume_instr: got %0h want 00a00593", id_instr); end
    id_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_drop();
    test_misaligned();
    test_timeout();
    test_wrap();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
